jtag_vdr_mc: RTL and testbench

Parametrised multi-channel JTAG virtual data register. Shifts DR_WIDTH-bit words between TDI/TDO and exposes per-channel read/write address registers plus a write-data register. Provides delayed read/write strobes with address auto-increment, and read-back of addresses and channel select. Sits between the TAP state decoder and the system-side memory/port logic; successor to the single-channel virtual DR.

---
 rtl/jtag_vdr_mc.sv | 220 ++++++++++++++++++++++
 tb/tb_jtag_vdr_mc.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_vdr_mc.sv
// -----------------------------------------------------------------------------
// jtag_vdr_mc -- multi-channel JTAG virtual data register.
//
// A DR_WIDTH-bit shift register sits between tdi and vdr_tdo. The TAP decoder
// drives capture_dr/shift_dr/update_dr, and one IR-decoded enable selects
// which register is captured or updated.
//
// Registers behind the shift path:
//   - ch_sel           : the channel that address/data operations use
//   - raddr[c]/waddr[c]: per-channel read/write addresses
//   - wdata_out        : write data for the system side
//
// Read-data captures and write-data updates each start a delayed strobe.
// When the strobe ends, the address of the channel that was latched with the
// event auto-increments, provided that channel's increment flag is still set.
//
// Ports:
//   tck, trst_n          JTAG clock; asynchronous active-low reset
//   tdi, vdr_tdo         serial in; serial out (vdr_tdo = vdr[0])
//   capture_dr, shift_dr, update_dr
//                        TAP state strobes
//   *_enable             IR decode: ident, chsel, raddr, waddr, rdata, wdata
//   rdata_in             system read data, captured on an rdata capture
//   wdata_out            write-data register
//   raddr_out/waddr_out  flattened addresses; channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
//   ch_sel               currently selected channel
//   rd_strobe/wr_strobe  one-cycle pulses, STROBE_DELAY cycles after their event
//   strobe_ch            channel of the active strobe (the read channel wins)
// -----------------------------------------------------------------------------
module jtag_vdr_mc #(
  parameter int                    DR_WIDTH     = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    NUM_CH       = 4,
  parameter int                    CH_BITS      = 2,
  parameter int                    STROBE_DELAY = 7,
  parameter logic [31:0]           IDENT_VALUE  = 32'h97d2f9ce,
  parameter logic [ADDR_WIDTH-1:0] RADDR_INIT   = ADDR_WIDTH'('h99)
) (
  input  logic                         tck,
  input  logic                         trst_n,
  input  logic                         tdi,
  output logic                         vdr_tdo,
  input  logic                         capture_dr,
  input  logic                         shift_dr,
  input  logic                         update_dr,
  input  logic                         ident_enable,
  input  logic                         chsel_enable,
  input  logic                         raddr_enable,
  input  logic                         waddr_enable,
  input  logic                         rdata_enable,
  input  logic                         wdata_enable,
  input  logic [DR_WIDTH-1:0]          rdata_in,
  output logic [DR_WIDTH-1:0]          wdata_out,
  output logic [NUM_CH*ADDR_WIDTH-1:0] raddr_out,
  output logic [NUM_CH*ADDR_WIDTH-1:0] waddr_out,
  output logic [CH_BITS-1:0]           ch_sel,
  output logic                         rd_strobe,
  output logic                         wr_strobe,
  output logic [CH_BITS-1:0]           strobe_ch
);

  localparam logic [DR_WIDTH-1:0] IDENT_DR = DR_WIDTH'(IDENT_VALUE);

  logic [DR_WIDTH-1:0]   vdr;
  logic [ADDR_WIDTH-1:0] raddr [NUM_CH];
  logic [ADDR_WIDTH-1:0] waddr [NUM_CH];
  logic [NUM_CH-1:0]     rd_inc;
  logic [NUM_CH-1:0]     wr_inc;

  // Delay pipelines: a valid bit plus the channel latched with each event.
  logic [STROBE_DELAY-1:0] rd_vld;
  logic [STROBE_DELAY-1:0] wr_vld;
  logic [CH_BITS-1:0]      rd_ch [STROBE_DELAY];
  logic [CH_BITS-1:0]      wr_ch [STROBE_DELAY];

  logic rd_evt;
  logic wr_evt;
  logic rd_evt_q;
  logic wr_evt_q;
  logic rd_fire;
  logic wr_fire;
  logic upd_chsel;
  logic upd_raddr;
  logic upd_waddr;
  logic upd_wdata;
  logic chsel_ok;
  logic [CH_BITS-1:0] rd_ch_now;
  logic [CH_BITS-1:0] wr_ch_now;

  assign rd_evt    = capture_dr & rdata_enable;
  assign wr_evt    = update_dr  & wdata_enable;

  // Only the rising edge of an event starts a strobe, so a capture or update
  // held high for several cycles still yields a single pulse.
  assign rd_fire   = rd_evt & ~rd_evt_q;
  assign wr_fire   = wr_evt & ~wr_evt_q;

  assign upd_chsel = update_dr & chsel_enable;
  assign upd_raddr = update_dr & raddr_enable;
  assign upd_waddr = update_dr & waddr_enable;
  assign upd_wdata = update_dr & wdata_enable;

  // The whole shifted value must name an existing channel. Checking only the
  // low CH_BITS would make out-of-range requests such as 5 alias onto a real
  // channel.
  assign chsel_ok  = (vdr < DR_WIDTH'(NUM_CH));

  assign rd_strobe = rd_vld[STROBE_DELAY-1];
  assign wr_strobe = wr_vld[STROBE_DELAY-1];
  assign rd_ch_now = rd_ch[STROBE_DELAY-1];
  assign wr_ch_now = wr_ch[STROBE_DELAY-1];
  assign strobe_ch = rd_strobe ? rd_ch_now : wr_ch_now;
  assign vdr_tdo   = vdr[0];

  // Shift register. A capture with a recognised enable overrides the shift
  // in the same cycle.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values and simulation ordering cannot change results.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      vdr <= '0;
    end else if (capture_dr && ident_enable) begin
      vdr <= IDENT_DR;
    end else if (capture_dr && chsel_enable) begin
      vdr <= DR_WIDTH'(ch_sel);
    end else if (capture_dr && raddr_enable) begin
      vdr <= DR_WIDTH'(raddr[ch_sel]);
    end else if (capture_dr && rdata_enable) begin
      vdr <= rdata_in;
    end else if (shift_dr) begin
      vdr <= {tdi, vdr[DR_WIDTH-1:1]};
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ch_sel    <= '0;
      wdata_out <= '0;
    end else begin
      if (upd_chsel && chsel_ok) ch_sel <= vdr[CH_BITS-1:0];
      if (upd_wdata)             wdata_out <= vdr;
    end
  end

  // Per-channel addresses and increment flags.
  //
  // An address update wins over an increment landing on the same channel in
  // the same edge. Both the address and the increment flag are taken from the
  // update, so the pending increment is dropped.
  //
  // NOTE: the address arrays are small and their reset values are visible on
  // the ports, so they are reset like any other register rather than being
  // treated as uninitialised memory.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        raddr[c] <= RADDR_INIT;
        waddr[c] <= '0;
      end
      rd_inc <= '0;
      wr_inc <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (upd_raddr && ch_sel == CH_BITS'(c)) begin
          raddr[c]  <= vdr[ADDR_WIDTH-1:0];
          rd_inc[c] <= 1'b0;
        end else begin
          if (rd_strobe && rd_ch_now == CH_BITS'(c) && rd_inc[c]) begin
            raddr[c] <= raddr[c] + ADDR_WIDTH'(1);
          end
          if (rd_evt && ch_sel == CH_BITS'(c)) rd_inc[c] <= 1'b1;
        end

        if (upd_waddr && ch_sel == CH_BITS'(c)) begin
          waddr[c]  <= vdr[ADDR_WIDTH-1:0];
          wr_inc[c] <= 1'b0;
        end else begin
          if (wr_strobe && wr_ch_now == CH_BITS'(c) && wr_inc[c]) begin
            waddr[c] <= waddr[c] + ADDR_WIDTH'(1);
          end
          if (upd_wdata && ch_sel == CH_BITS'(c)) wr_inc[c] <= 1'b1;
        end
      end
    end
  end

  // Strobe delay lines. The channel travels alongside the valid bit, so a
  // later change of ch_sel cannot redirect a strobe that is already in flight.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      rd_evt_q <= 1'b0;
      wr_evt_q <= 1'b0;
      rd_vld   <= '0;
      wr_vld   <= '0;
      for (int i = 0; i < STROBE_DELAY; i++) begin
        rd_ch[i] <= '0;
        wr_ch[i] <= '0;
      end
    end else begin
      rd_evt_q  <= rd_evt;
      wr_evt_q  <= wr_evt;
      rd_vld[0] <= rd_fire;
      wr_vld[0] <= wr_fire;
      rd_ch[0]  <= ch_sel;
      wr_ch[0]  <= ch_sel;
      for (int i = 1; i < STROBE_DELAY; i++) begin
        rd_vld[i] <= rd_vld[i-1];
        wr_vld[i] <= wr_vld[i-1];
        rd_ch[i]  <= rd_ch[i-1];
        wr_ch[i]  <= wr_ch[i-1];
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_flat
    assign raddr_out[c*ADDR_WIDTH +: ADDR_WIDTH] = raddr[c];
    assign waddr_out[c*ADDR_WIDTH +: ADDR_WIDTH] = waddr[c];
  end

endmodule

// File: tb/tb_jtag_vdr_mc.sv
// -----------------------------------------------------------------------------
// tb_jtag_vdr_mc -- self-checking bench for jtag_vdr_mc (default parameters).
//
// Model: a transaction-level model of the register state. Pending strobes are
// kept as a queue of {due cycle, channel, kind} records. A compare process
// checks every DUT output against the model on each falling edge.
//
// Directed scenarios: reset values, ident scan-out, channel reads with
// overlapping strobes, a write with address wrap, an address update colliding
// with an increment, an out-of-range channel select, and a reset mid-delay.
// Each scenario also pins its result with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_jtag_vdr_mc;

  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          NCH   = 4;
  localparam int          CB    = 2;
  localparam int          SD    = 7;
  localparam logic [31:0] IDENT = 32'h97d2f9ce;

  typedef enum int {E_NONE, E_IDENT, E_CHSEL, E_RADDR, E_WADDR, E_RDATA, E_WDATA} en_e;
  typedef struct {int due; int ch; bit rd;} pend_t;

  logic              tck = 1'b0;
  logic              trst_n = 1'b0;
  logic              tdi = 1'b0;
  logic              capture_dr = 1'b0;
  logic              shift_dr = 1'b0;
  logic              update_dr = 1'b0;
  logic              ident_enable = 1'b0;
  logic              chsel_enable = 1'b0;
  logic              raddr_enable = 1'b0;
  logic              waddr_enable = 1'b0;
  logic              rdata_enable = 1'b0;
  logic              wdata_enable = 1'b0;
  logic [DW-1:0]     rdata_in = '0;
  logic              vdr_tdo;
  logic [DW-1:0]     wdata_out;
  logic [NCH*AW-1:0] raddr_out;
  logic [NCH*AW-1:0] waddr_out;
  logic [CB-1:0]     ch_sel;
  logic              rd_strobe;
  logic              wr_strobe;
  logic [CB-1:0]     strobe_ch;

  jtag_vdr_mc #(
    .DR_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH), .CH_BITS(CB),
    .STROBE_DELAY(SD), .IDENT_VALUE(IDENT), .RADDR_INIT(AW'('h99))
  ) dut (
    .tck(tck), .trst_n(trst_n), .tdi(tdi), .vdr_tdo(vdr_tdo),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .ident_enable(ident_enable), .chsel_enable(chsel_enable),
    .raddr_enable(raddr_enable), .waddr_enable(waddr_enable),
    .rdata_enable(rdata_enable), .wdata_enable(wdata_enable),
    .rdata_in(rdata_in), .wdata_out(wdata_out),
    .raddr_out(raddr_out), .waddr_out(waddr_out), .ch_sel(ch_sel),
    .rd_strobe(rd_strobe), .wr_strobe(wr_strobe), .strobe_ch(strobe_ch)
  );

  always #5 tck = ~tck;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int rd_seen[$];
  int wr_seen[$];

  // Model state.
  logic [DW-1:0] m_vdr;
  logic [DW-1:0] m_wdata;
  logic [AW-1:0] m_raddr [NCH];
  logic [AW-1:0] m_waddr [NCH];
  bit            m_rinc [NCH];
  bit            m_winc [NCH];
  int            m_ch;
  bit            m_prev_rd;
  bit            m_prev_wr;
  pend_t         pend[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_vdr = '0;
    m_wdata = '0;
    m_ch = 0;
    m_prev_rd = 0;
    m_prev_wr = 0;
    for (int c = 0; c < NCH; c++) begin
      m_raddr[c] = AW'('h99);
      m_waddr[c] = '0;
      m_rinc[c]  = 0;
      m_winc[c]  = 0;
    end
    pend.delete();
  endtask

  // One clock edge ending cycle `cyc`. Values loaded by a capture come from
  // the state before the edge. Increments use the flags before the edge. An
  // update applied afterwards overwrites a same-channel increment.
  task automatic model_step();
    logic [DW-1:0] nv;
    int            oc;
    bit            rev;
    bit            wev;
    nv  = m_vdr;
    oc  = m_ch;
    rev = capture_dr && rdata_enable;
    wev = update_dr && wdata_enable;
    if (capture_dr && ident_enable)      nv = DW'(IDENT);
    else if (capture_dr && chsel_enable) nv = DW'(oc);
    else if (capture_dr && raddr_enable) nv = DW'(m_raddr[oc]);
    else if (capture_dr && rdata_enable) nv = rdata_in;
    else if (shift_dr)                   nv = (m_vdr >> 1) | (DW'(tdi) << (DW-1));
    foreach (pend[i]) begin
      if (pend[i].due == cyc) begin
        if (pend[i].rd) begin
          if (m_rinc[pend[i].ch]) m_raddr[pend[i].ch] = m_raddr[pend[i].ch] + AW'(1);
        end else begin
          if (m_winc[pend[i].ch]) m_waddr[pend[i].ch] = m_waddr[pend[i].ch] + AW'(1);
        end
      end
    end
    pend = pend.find(x) with (x.due > cyc);
    if (update_dr) begin
      if (chsel_enable && m_vdr < DW'(NCH)) m_ch = int'(m_vdr);
      if (raddr_enable) begin m_raddr[oc] = m_vdr[AW-1:0]; m_rinc[oc] = 0; end
      if (waddr_enable) begin m_waddr[oc] = m_vdr[AW-1:0]; m_winc[oc] = 0; end
      if (wdata_enable) begin m_wdata = m_vdr; m_winc[oc] = 1; end
    end
    if (rev) m_rinc[oc] = 1;
    if (rev && !m_prev_rd) pend.push_back('{cyc + SD, oc, 1'b1});
    if (wev && !m_prev_wr) pend.push_back('{cyc + SD, oc, 1'b0});
    m_prev_rd = rev;
    m_prev_wr = wev;
    m_vdr     = nv;
  endtask

  initial forever begin
    @(posedge tck);
    if (!trst_n) model_reset();
    else         model_step();
    cyc++;
  end

  // Compare process: every falling edge outside reset.
  initial forever begin
    bit er;
    bit ew;
    int erc;
    int ewc;
    @(negedge tck);
    if (trst_n) begin
      er = 0; ew = 0; erc = 0; ewc = 0;
      foreach (pend[i]) begin
        if (pend[i].due == cyc) begin
          if (pend[i].rd) begin er = 1; erc = pend[i].ch; end
          else            begin ew = 1; ewc = pend[i].ch; end
        end
      end
      check("tdo", vdr_tdo, m_vdr[0]);
      check("wdata_out", wdata_out, m_wdata);
      check("ch_sel", ch_sel, m_ch);
      for (int c = 0; c < NCH; c++) begin
        check($sformatf("raddr%0d", c), raddr_out[c*AW +: AW], m_raddr[c]);
        check($sformatf("waddr%0d", c), waddr_out[c*AW +: AW], m_waddr[c]);
      end
      check("rd_strobe", rd_strobe, er);
      check("wr_strobe", wr_strobe, ew);
      if (er || ew) check("strobe_ch", strobe_ch, er ? erc : ewc);
      if (rd_strobe) rd_seen.push_back(cyc);
      if (wr_strobe) wr_seen.push_back(cyc);
    end
  end

  function automatic int count_in(input int q[$], input int lo, input int hi);
    int n = 0;
    foreach (q[i]) if (q[i] >= lo && q[i] < hi) n++;
    return n;
  endfunction

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clk1();
    @(posedge tck);
    #1;
  endtask

  task automatic set_en(input en_e e);
    ident_enable = (e == E_IDENT);
    chsel_enable = (e == E_CHSEL);
    raddr_enable = (e == E_RADDR);
    waddr_enable = (e == E_WADDR);
    rdata_enable = (e == E_RDATA);
    wdata_enable = (e == E_WDATA);
  endtask

  task automatic idle(input int n);
    capture_dr = 0; shift_dr = 0; update_dr = 0; tdi = 0;
    set_en(E_NONE);
    repeat (n) clk1();
  endtask

  task automatic cap(input en_e e);
    capture_dr = 1; set_en(e);
    clk1();
    capture_dr = 0; set_en(E_NONE);
  endtask

  task automatic upd(input en_e e);
    update_dr = 1; set_en(e);
    clk1();
    update_dr = 0; set_en(E_NONE);
  endtask

  task automatic shift_in(input logic [DW-1:0] v);
    for (int i = 0; i < DW; i++) begin
      shift_dr = 1; tdi = v[i];
      clk1();
    end
    shift_dr = 0; tdi = 0;
  endtask

  task automatic shift_out(output logic [DW-1:0] v);
    for (int i = 0; i < DW; i++) begin
      v[i] = vdr_tdo;
      shift_dr = 1; tdi = 0;
      clk1();
    end
    shift_dr = 0;
  endtask

  task automatic wr_reg(input en_e e, input logic [DW-1:0] v);
    shift_in(v);
    upd(e);
  endtask

  task automatic rd_reg(input en_e e, output logic [DW-1:0] v);
    cap(e);
    shift_out(v);
  endtask

  initial begin
    logic [DW-1:0] v;
    int c0;
    int c1;
    int c2;

    trst_n = 0;
    repeat (3) clk1();
    trst_n = 1;
    clk1();
    check("rst_ch_sel", ch_sel, 0);
    check("rst_wdata", wdata_out, 0);
    check("rst_strobes", {rd_strobe, wr_strobe}, 0);
    for (int c = 0; c < NCH; c++) begin
      check("rst_raddr", raddr_out[c*AW +: AW], 'h99);
      check("rst_waddr", waddr_out[c*AW +: AW], 0);
    end

    // Ident scans out LSB first.
    rd_reg(E_IDENT, v);
    check("ident_tdo", v, 32'h97d2f9ce);

    // Channel 2: three reads, the last two only 3 cycles apart.
    wr_reg(E_CHSEL, 2);
    check("ch_sel_2", ch_sel, 2);
    wr_reg(E_RADDR, 'h10);
    rdata_in = 32'h1234_5678;
    c0 = cyc; cap(E_RDATA);
    shift_out(v);
    check("rdata_tdo", v, 32'h1234_5678);
    c1 = cyc; cap(E_RDATA);
    idle(2);
    c2 = cyc; cap(E_RDATA);
    idle(10);
    check("rd1_delay", in_q(rd_seen, c0 + SD), 1);
    check("rd2_delay", in_q(rd_seen, c1 + SD), 1);
    check("rd3_delay", in_q(rd_seen, c2 + SD), 1);
    check("rd_count3", count_in(rd_seen, c0, cyc), 3);
    check("raddr2_13", raddr_out[2*AW +: AW], 'h13);
    check("raddr0_keep", raddr_out[0 +: AW], 'h99);
    check("raddr1_keep", raddr_out[AW +: AW], 'h99);
    check("raddr3_keep", raddr_out[3*AW +: AW], 'h99);

    // A capture held for three cycles gives one strobe.
    c0 = cyc;
    capture_dr = 1; set_en(E_RDATA);
    repeat (3) clk1();
    idle(12);
    check("held_one_strobe", count_in(rd_seen, c0, cyc), 1);
    check("raddr2_14", raddr_out[2*AW +: AW], 'h14);
    rd_reg(E_RADDR, v);
    check("raddr2_readback", v, 'h14);

    // Channel 1 write; the address wraps from all-ones to zero.
    wr_reg(E_CHSEL, 1);
    wr_reg(E_WADDR, 32'hFFFF_FFFF);
    shift_in(32'hA5);
    c0 = cyc; upd(E_WDATA);
    check("wdata_a5", wdata_out, 32'hA5);
    check("waddr1_pre", waddr_out[AW +: AW], 32'hFFFF_FFFF);
    idle(10);
    check("wr_delay", in_q(wr_seen, c0 + SD), 1);
    check("waddr1_wrap", waddr_out[AW +: AW], 0);

    // Channel 0: an address update lands in the strobe cycle and wins.
    wr_reg(E_CHSEL, 0);
    rdata_in = 32'h40;
    c0 = cyc; cap(E_RDATA);
    idle(6);
    upd(E_RADDR);
    idle(5);
    check("rd_upd_strobe", in_q(rd_seen, c0 + SD), 1);
    check("raddr0_40", raddr_out[0 +: AW], 'h40);

    // An out-of-range channel select is ignored.
    wr_reg(E_CHSEL, 3);
    wr_reg(E_CHSEL, 5);
    check("chsel_ignore", ch_sel, 3);
    rd_reg(E_CHSEL, v);
    check("chsel_readback", v, 3);

    // A reset in cycle 3 after a read capture drops the strobe and increment.
    wr_reg(E_RADDR, 'h55);
    check("raddr3_55", raddr_out[3*AW +: AW], 'h55);
    c0 = cyc; cap(E_RDATA);
    idle(2);
    trst_n = 0;
    clk1();
    clk1();
    trst_n = 1;
    idle(10);
    check("rst_no_strobe", count_in(rd_seen, c0, cyc), 0);
    check("rst_raddr3", raddr_out[3*AW +: AW], 'h99);
    check("rst_ch_sel_0", ch_sel, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
